// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: physical line address, cacheline,
// arbiter FSM states and the latched D-side request.
package mem_arbiter_pkg;

  localparam int PPTR_W          = 32;
  localparam int CL_W            = 128;
  localparam int MEM_LATENCY_DEF = 5;

  typedef logic [PPTR_W-1:0] pptr_t;
  typedef logic [CL_W-1:0]   cacheline_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Requester index used by the round-robin arbiter and service tracking
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic       wen;
    pptr_t      addr;
    cacheline_t wdata;
  } dc_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant. On a tie the port that did not win last time
// is chosen; last_grant only moves when a grant is actually taken (en).
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_port
);

  logic last_grant;

  always_comb begin
    gnt_valid = |req;
    gnt_port  = PORT_I;
    if (req == 2'b10) begin
      gnt_port = PORT_D;
    end else if (req == 2'b11) begin
      gnt_port = ~last_grant;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_D;
    end else if (en && gnt_valid) begin
      last_grant <= gnt_port;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between I-cache refills and D-cache
// refills/writebacks; one latched request per side, one transaction in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ic_req_ren,
  input  pptr_t      ic_req_addr,
  output logic       ic_busy,
  output logic       ic_rec_en,
  output pptr_t      ic_rec_addr,
  output cacheline_t ic_rec_cacheline,
  input  logic       dc_req_ren,
  input  logic       dc_req_wen,
  input  pptr_t      dc_req_addr,
  input  cacheline_t dc_req_wdata,
  output logic       dc_busy,
  output logic       dc_rec_en,
  output logic       dc_wack,
  output pptr_t      dc_rec_addr,
  output cacheline_t dc_rec_cacheline,
  input  logic       exc_en,
  output logic       mem_ren,
  output logic       mem_wen,
  output pptr_t      mem_addr,
  output cacheline_t mem_wdata,
  input  cacheline_t mem_rdata
);

  arb_state_t       state;
  logic             ic_pending;
  logic             dc_pending;
  pptr_t            ic_addr_q;
  dc_req_t          dc_q;
  logic             svc_port;
  logic             svc_wen;
  logic [CNT_W-1:0] cnt;
  logic             can_grant;
  logic             gnt_valid;
  logic             gnt_port;
  logic             grant;
  logic             ic_in_svc;
  logic             dc_in_svc;
  logic             ic_accept;
  logic             dc_accept;

  assign can_grant = (state == IDLE) || (state == RESP);
  assign grant     = can_grant && gnt_valid;
  assign ic_in_svc = (state != IDLE) && (svc_port == PORT_I);
  assign dc_in_svc = (state != IDLE) && (svc_port == PORT_D);

  // A port's own RESP cycle already frees its slot, so a new pulse there is taken
  assign ic_accept = ic_req_ren && !ic_pending && (!ic_in_svc || state == RESP);
  assign dc_accept = (dc_req_ren || dc_req_wen) && !dc_pending &&
                     (!dc_in_svc || state == RESP);

  assign ic_busy = ic_pending || ic_in_svc;
  assign dc_busy = dc_pending || dc_in_svc;

  // A flushed fetch must not win arbitration in the same cycle it is killed
  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({dc_pending, ic_pending & ~exc_en}),
    .en        (can_grant),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      ic_pending       <= 1'b0;
      dc_pending       <= 1'b0;
      ic_addr_q        <= '0;
      dc_q             <= '0;
      svc_port         <= PORT_D;
      svc_wen          <= 1'b0;
      cnt              <= '0;
      mem_ren          <= 1'b0;
      mem_wen          <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      ic_rec_en        <= 1'b0;
      ic_rec_addr      <= '0;
      ic_rec_cacheline <= '0;
      dc_rec_en        <= 1'b0;
      dc_wack          <= 1'b0;
      dc_rec_addr      <= '0;
      dc_rec_cacheline <= '0;
    end else begin
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      ic_rec_en <= 1'b0;
      dc_rec_en <= 1'b0;
      dc_wack   <= 1'b0;

      if (exc_en) begin
        ic_pending <= 1'b0;
      end else if (ic_accept) begin
        ic_pending <= 1'b1;
        ic_addr_q  <= ic_req_addr;
      end else if (grant && gnt_port == PORT_I) begin
        ic_pending <= 1'b0;
      end

      if (dc_accept) begin
        dc_pending <= 1'b1;
        dc_q       <= '{wen: dc_req_wen, addr: dc_req_addr, wdata: dc_req_wdata};
      end else if (grant && gnt_port == PORT_D) begin
        dc_pending <= 1'b0;
      end

      case (state)
        IDLE, RESP: begin
          if (grant) begin
            state    <= WAIT;
            svc_port <= gnt_port;
            cnt      <= CNT_W'(MEM_LATENCY);
            if (gnt_port == PORT_I) begin
              svc_wen  <= 1'b0;
              mem_ren  <= 1'b1;
              mem_addr <= ic_addr_q;
            end else begin
              svc_wen   <= dc_q.wen;
              mem_ren   <= ~dc_q.wen;
              mem_wen   <= dc_q.wen;
              mem_addr  <= dc_q.addr;
              mem_wdata <= dc_q.wdata;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          // cnt reaches zero in the cycle the memory presents its read data
          if (cnt == '0) begin
            state <= RESP;
            if (svc_wen) begin
              dc_wack <= 1'b1;
            end else if (svc_port == PORT_I) begin
              ic_rec_en        <= 1'b1;
              ic_rec_addr      <= mem_addr;
              ic_rec_cacheline <= mem_rdata;
            end else begin
              dc_rec_en        <= 1'b1;
              dc_rec_addr      <= mem_addr;
              dc_rec_cacheline <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory/response
// events, a negedge monitor pops and compares each one the DUT presents.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LAT    = 5;
  localparam int K_MRD  = 1;
  localparam int K_MWR  = 2;
  localparam int K_IREC = 3;
  localparam int K_DREC = 4;
  localparam int K_WACK = 5;

  typedef struct {
    int         kind;
    int         cyc;
    pptr_t      addr;
    cacheline_t data;
  } ev_t;

  typedef struct {
    int         cyc;
    cacheline_t data;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ic_req_ren = 1'b0;
  pptr_t      ic_req_addr = '0;
  logic       ic_busy, ic_rec_en;
  pptr_t      ic_rec_addr;
  cacheline_t ic_rec_cacheline;
  logic       dc_req_ren = 1'b0;
  logic       dc_req_wen = 1'b0;
  pptr_t      dc_req_addr = '0;
  cacheline_t dc_req_wdata = '0;
  logic       dc_busy, dc_rec_en, dc_wack;
  pptr_t      dc_rec_addr;
  cacheline_t dc_rec_cacheline;
  logic       exc_en = 1'b0;
  logic       mem_ren, mem_wen;
  pptr_t      mem_addr;
  cacheline_t mem_wdata;
  cacheline_t mem_rdata = '0;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  ev_t  exp_q[$];
  rd_t  mem_q[$];

  localparam cacheline_t GARBAGE = {4{32'hBAD0_BAD0}};
  localparam cacheline_t WDATA   = {16{8'hA5}};

  mem_arbiter #(.MEM_LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ic_req_ren(ic_req_ren), .ic_req_addr(ic_req_addr), .ic_busy(ic_busy),
    .ic_rec_en(ic_rec_en), .ic_rec_addr(ic_rec_addr), .ic_rec_cacheline(ic_rec_cacheline),
    .dc_req_ren(dc_req_ren), .dc_req_wen(dc_req_wen), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_busy(dc_busy), .dc_rec_en(dc_rec_en),
    .dc_wack(dc_wack), .dc_rec_addr(dc_rec_addr), .dc_rec_cacheline(dc_rec_cacheline),
    .exc_en(exc_en), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic cacheline_t line_of(pptr_t a);
    return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, a ^ 32'h3333_3333, a ^ 32'h4444_4444};
  endfunction

  task automatic push_exp(int k, int c, pptr_t a, cacheline_t d);
    ev_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check(string name, cacheline_t act, cacheline_t req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ic_busy || dc_busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 128'(n >= 100), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Memory model: data valid exactly LAT cycles after mem_ren, garbage otherwise
  always @(posedge clk) begin
    #1;
    while (mem_q.size() > 0 && mem_q[0].cyc < cyc) void'(mem_q.pop_front());
    if (mem_q.size() > 0 && mem_q[0].cyc == cyc) mem_rdata = mem_q.pop_front().data;
    else mem_rdata = GARBAGE;
  end

  // Monitor: at most one observable event per cycle
  always @(negedge clk) begin
    int         k;
    int         nev;
    pptr_t      a;
    cacheline_t d;
    ev_t        e;
    k = 0; a = '0; d = '0;
    nev = int'(mem_ren) + int'(mem_wen) + int'(ic_rec_en) + int'(dc_rec_en) + int'(dc_wack);
    if (mem_ren)        begin k = K_MRD;  a = mem_addr; end
    else if (mem_wen)   begin k = K_MWR;  a = mem_addr; d = mem_wdata; end
    else if (ic_rec_en) begin k = K_IREC; a = ic_rec_addr; d = ic_rec_cacheline; end
    else if (dc_rec_en) begin k = K_DREC; a = dc_rec_addr; d = dc_rec_cacheline; end
    else if (dc_wack)   k = K_WACK;
    if (nev > 1) begin
      checks++;
      $display("FAIL multi_event@%0d: %0d strobes high, expected at most 1", cyc, nev);
    end
    if (mem_ren) mem_q.push_back('{cyc: cyc + LAT, data: line_of(mem_addr)});
    if (k != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event@%0d: got kind=%0d addr=%h, expected none", cyc, k, a);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == k && e.addr == a && e.data == d && (e.cyc < 0 || e.cyc == cyc)) begin
          passes++;
          $display("event ok @%0d kind=%0d addr=%h", cyc, k, a);
        end else begin
          $display("FAIL event@%0d: got kind=%0d addr=%h data=%h, expected kind=%0d cyc=%0d addr=%h data=%h",
                   cyc, k, a, d, e.kind, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    int b;
    #1;
    check("rst_mem_ren", 128'(mem_ren), 128'(0));
    check("rst_mem_wen", 128'(mem_wen), 128'(0));
    check("rst_busy", 128'({ic_busy, dc_busy}), 128'(0));
    check("rst_rec_en", 128'({ic_rec_en, dc_rec_en, dc_wack}), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single I read
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h0040;
    push_exp(K_MRD, b + 2, 32'h0040, '0);
    push_exp(K_IREC, b + 8, 32'h0040, line_of(32'h0040));
    @(negedge clk); ic_req_ren = 1'b0;
    check("t1_busy_c1", 128'(ic_busy), 128'(1));
    wait_until(b + 8); check("t1_busy_c8", 128'(ic_busy), 128'(1));
    wait_until(b + 9); check("t1_busy_c9", 128'(ic_busy), 128'(0));
    wait_idle();

    // Simultaneous I/D after reset: I first, then tie goes to I again
    do_reset();
    for (int t = 0; t < 2; t++) begin
      b = cyc;
      ic_req_ren = 1'b1; ic_req_addr = (t == 0) ? 32'h0100 : 32'h0180;
      dc_req_ren = 1'b1; dc_req_addr = (t == 0) ? 32'h0200 : 32'h0280;
      push_exp(K_MRD, b + 2, ic_req_addr, '0);
      push_exp(K_IREC, b + 8, ic_req_addr, line_of(ic_req_addr));
      push_exp(K_MRD, b + 9, dc_req_addr, '0);
      push_exp(K_DREC, b + 15, dc_req_addr, line_of(dc_req_addr));
      @(negedge clk); ic_req_ren = 1'b0; dc_req_ren = 1'b0;
      wait_idle();
    end

    // After an I-only grant a tie goes to D
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h01C0;
    push_exp(K_MRD, b + 2, 32'h01C0, '0);
    push_exp(K_IREC, b + 8, 32'h01C0, line_of(32'h01C0));
    @(negedge clk); ic_req_ren = 1'b0;
    wait_idle();
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h01E0;
    dc_req_ren = 1'b1; dc_req_addr = 32'h02E0;
    push_exp(K_MRD, b + 2, 32'h02E0, '0);
    push_exp(K_DREC, b + 8, 32'h02E0, line_of(32'h02E0));
    push_exp(K_MRD, b + 9, 32'h01E0, '0);
    push_exp(K_IREC, b + 15, 32'h01E0, line_of(32'h01E0));
    @(negedge clk); ic_req_ren = 1'b0; dc_req_ren = 1'b0;
    wait_idle();

    // D writeback; D refill outputs hold their previous value
    b = cyc;
    dc_req_wen = 1'b1; dc_req_addr = 32'h0300; dc_req_wdata = WDATA;
    push_exp(K_MWR, b + 2, 32'h0300, WDATA);
    push_exp(K_WACK, b + 8, '0, '0);
    @(negedge clk); dc_req_wen = 1'b0;
    wait_until(b + 9);
    check("t3_hold_addr", 128'(dc_rec_addr), 128'(32'h02E0));
    check("t3_hold_line", dc_rec_cacheline, line_of(32'h02E0));
    wait_idle();

    // Re-request while busy is dropped; request in RESP cycle is taken
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h0400;
    push_exp(K_MRD, b + 2, 32'h0400, '0);
    push_exp(K_IREC, b + 8, 32'h0400, line_of(32'h0400));
    push_exp(K_MRD, -1, 32'h0480, '0);
    push_exp(K_IREC, -1, 32'h0480, line_of(32'h0480));
    @(negedge clk); ic_req_ren = 1'b0;
    wait_until(b + 3);
    ic_req_ren = 1'b1; ic_req_addr = 32'h0440;
    @(negedge clk); ic_req_ren = 1'b0;
    wait_until(b + 8);
    ic_req_ren = 1'b1; ic_req_addr = 32'h0480;
    @(negedge clk); ic_req_ren = 1'b0;
    wait_idle();

    // Flush of an I request still queued behind an in-service D read
    b = cyc;
    dc_req_ren = 1'b1; dc_req_addr = 32'h0500;
    push_exp(K_MRD, b + 2, 32'h0500, '0);
    push_exp(K_DREC, b + 8, 32'h0500, line_of(32'h0500));
    @(negedge clk); dc_req_ren = 1'b0;
    wait_until(b + 3);
    ic_req_ren = 1'b1; ic_req_addr = 32'h0540;
    @(negedge clk); ic_req_ren = 1'b0;
    check("t5_ic_pending", 128'(ic_busy), 128'(1));
    wait_until(b + 5);
    exc_en = 1'b1;
    @(negedge clk); exc_en = 1'b0;
    check("t5_ic_flushed", 128'(ic_busy), 128'(0));
    check("t5_dc_unaffected", 128'(dc_busy), 128'(1));
    wait_idle();

    // Flush during an in-service I fetch: it still delivers
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h0600;
    push_exp(K_MRD, b + 2, 32'h0600, '0);
    push_exp(K_IREC, b + 8, 32'h0600, line_of(32'h0600));
    @(negedge clk); ic_req_ren = 1'b0;
    wait_until(b + 4);
    exc_en = 1'b1;
    @(negedge clk); exc_en = 1'b0;
    check("t5b_busy_in_svc", 128'(ic_busy), 128'(1));
    wait_idle();

    // Reset in the middle of a WAIT; stale read data must be ignored
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h0700;
    push_exp(K_MRD, b + 2, 32'h0700, '0);
    @(negedge clk); ic_req_ren = 1'b0;
    wait_until(b + 4);
    rst = 1'b0;
    #1;
    check("t6_rst_busy", 128'(ic_busy), 128'(0));
    check("t6_rst_mem_addr", 128'(mem_addr), 128'(0));
    check("t6_rst_rec_addr", 128'(ic_rec_addr), 128'(0));
    check("t6_rst_rec_line", ic_rec_cacheline, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_until(b + 12);
    b = cyc;
    ic_req_ren = 1'b1; ic_req_addr = 32'h0740;
    push_exp(K_MRD, b + 2, 32'h0740, '0);
    push_exp(K_IREC, b + 8, 32'h0740, line_of(32'h0740));
    @(negedge clk); ic_req_ren = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    check("drain_expected", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
